// File: rtl/id_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs buffered long-latency results.
// Define WB_SCOREBOARD_EN to enable the pending-destination scoreboard.
module id_wb_arbiter #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int REGFILE_DEPTH      = 32,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Wb_valid,
    output logic                          Wb_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Wb_rd,
    input  logic [REG_DATA_WIDTH-1:0]     Wb_data,
    input  logic                          Ll_valid,
    output logic                          Ll_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Ll_rd,
    input  logic [REG_DATA_WIDTH-1:0]     Ll_data,
    input  logic                          Issue_valid,
    output logic                          Issue_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Issue_rd,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Rs2_addr,
    output logic                          Rs1_busy,
    output logic                          Rs2_busy,
    output logic [REGFILE_ADDR_WIDTH-1:0] Rd_addr,
    output logic [REG_DATA_WIDTH-1:0]     Rd_wr_data,
    output logic                          Rd_wr_en
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic                          full_q, full_d;
    logic [REGFILE_ADDR_WIDTH-1:0] buf_rd_q, buf_rd_d;
    logic [REG_DATA_WIDTH-1:0]     buf_data_q, buf_data_d;
    logic [CW-1:0]                 starve_q, starve_d;
    logic                          force_gnt;
    logic                          buf_gnt;
    logic                          wb_gnt;

    always_comb begin
        force_gnt  = full_q && (starve_q == LIMIT);
        buf_gnt    = force_gnt || (full_q && !Wb_valid);
        wb_gnt     = !force_gnt && Wb_valid;
        Wb_ready   = !force_gnt;
        Ll_ready   = !full_q;
        Rd_addr    = buf_gnt ? buf_rd_q : Wb_rd;
        Rd_wr_data = buf_gnt ? buf_data_q : Wb_data;
        // Gated by reset so a held-low reset never leaks a write.
        Rd_wr_en   = Reset_n && (buf_gnt || wb_gnt) && (Rd_addr != '0);
        full_d     = full_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        starve_d   = starve_q;
        if (buf_gnt) begin
            full_d = 1'b0;
        end else if (Ll_valid && !full_q) begin
            full_d     = 1'b1;
            buf_rd_d   = Ll_rd;
            buf_data_d = Ll_data;
        end
        if (buf_gnt || !full_q) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            full_q     <= 1'b0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            starve_q   <= '0;
        end else begin
            full_q     <= full_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            starve_q   <= starve_d;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [REGFILE_DEPTH-1:0] pending_q, pending_d;
    logic [REGFILE_DEPTH-1:0] set_vec, clr_vec;
    logic                     clr_issue;

    always_comb begin
        set_vec     = '0;
        clr_vec     = '0;
        clr_issue   = buf_gnt && (buf_rd_q == Issue_rd);
        Issue_ready = !pending_q[Issue_rd] || clr_issue;
        Rs1_busy    = pending_q[Rs1_addr] &&
                      !(buf_gnt && (buf_rd_q == Rs1_addr));
        Rs2_busy    = pending_q[Rs2_addr] &&
                      !(buf_gnt && (buf_rd_q == Rs2_addr));
        if (buf_gnt) clr_vec[buf_rd_q] = 1'b1;
        if (Issue_valid && Issue_ready && (Issue_rd != '0))
            set_vec[Issue_rd] = 1'b1;
        // Set is applied after clear so a same-edge re-issue keeps the bit.
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) pending_q <= '0;
        else          pending_q <= pending_d;
    end
`else
    logic unused_issue;

    assign unused_issue = ^{Issue_valid, Issue_rd, Rs1_addr, Rs2_addr};
    assign Issue_ready  = 1'b1;
    assign Rs1_busy     = 1'b0;
    assign Rs2_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_id_wb_arbiter.sv
// Directed self-checking bench for id_wb_arbiter (STARVE_LIMIT = 4).
// Expected busy/issue values follow WB_SCOREBOARD_EN when it is defined.
module tb_id_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Wb_valid, Wb_ready;
    logic [4:0]  Wb_rd;
    logic [31:0] Wb_data;
    logic        Ll_valid, Ll_ready;
    logic [4:0]  Ll_rd;
    logic [31:0] Ll_data;
    logic        Issue_valid, Issue_ready;
    logic [4:0]  Issue_rd, Rs1_addr, Rs2_addr;
    logic        Rs1_busy, Rs2_busy;
    logic [4:0]  Rd_addr;
    logic [31:0] Rd_wr_data;
    logic        Rd_wr_en;

    int checks = 0;
    int failures = 0;

`ifdef WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    id_wb_arbiter #(
        .REG_DATA_WIDTH(32),
        .REGFILE_ADDR_WIDTH(5),
        .REGFILE_DEPTH(32),
        .STARVE_LIMIT(4)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Wb_valid(Wb_valid), .Wb_ready(Wb_ready),
        .Wb_rd(Wb_rd), .Wb_data(Wb_data),
        .Ll_valid(Ll_valid), .Ll_ready(Ll_ready),
        .Ll_rd(Ll_rd), .Ll_data(Ll_data),
        .Issue_valid(Issue_valid), .Issue_ready(Issue_ready),
        .Issue_rd(Issue_rd),
        .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
        .Rs1_busy(Rs1_busy), .Rs2_busy(Rs2_busy),
        .Rd_addr(Rd_addr), .Rd_wr_data(Rd_wr_data),
        .Rd_wr_en(Rd_wr_en)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        Wb_valid = 1'b1; Wb_rd = 5'd5; Wb_data = 32'h1111;
        Ll_valid = 1'b1; Ll_rd = 5'd6; Ll_data = 32'h2222;
        Issue_valid = 1'b1; Issue_rd = 5'd6;
        Rs1_addr = 5'd6; Rs2_addr = 5'd0;
        tick(); tick();
        #2;
        check("rst_wr_en", Rd_wr_en, 0);
        check("rst_ll_ready", Ll_ready, 1);
        check("rst_wb_ready", Wb_ready, 1);
        check("rst_issue_ready", Issue_ready, 1);
        check("rst_rs1_busy", Rs1_busy, 0);
        check("rst_rs2_busy", Rs2_busy, 0);

        tick();
        Reset_n = 1'b1;
        Wb_valid = 1'b0; Ll_valid = 1'b0; Issue_valid = 1'b0;
        #2;
        check("post_rst_no_write", Rd_wr_en, 0);
        check("post_rst_ll_ready", Ll_ready, 1);

        // WB pass-through
        tick();
        Wb_valid = 1'b1; Wb_rd = 5'd5; Wb_data = 32'hDEADBEEF;
        #2;
        check("wb_en", Rd_wr_en, 1);
        check("wb_addr", Rd_addr, 5);
        check("wb_data", Rd_wr_data, 32'hDEADBEEF);
        check("wb_ready", Wb_ready, 1);
        tick();
        Wb_rd = 5'd0;
        #2;
        check("wb_x0_en", Rd_wr_en, 0);
        check("wb_x0_ready", Wb_ready, 1);
        tick();
        Wb_valid = 1'b0;

        // Idle drain of rd 7
        Issue_valid = 1'b1; Issue_rd = 5'd7; Rs1_addr = 5'd7;
        #2;
        check("drain_issue_ready", Issue_ready, 1);
        check("drain_busy_pre", Rs1_busy, 0);
        tick();
        Issue_valid = 1'b0;
        Ll_valid = 1'b1; Ll_rd = 5'd7; Ll_data = 32'h1234;
        #2;
        check("drain_busy_set", Rs1_busy, 32'(SB));
        check("drain_ll_ready", Ll_ready, 1);
        check("drain_no_wr", Rd_wr_en, 0);
        tick();
        Ll_valid = 1'b0;
        #2;
        check("drain_full", Ll_ready, 0);
        check("drain_wr_en", Rd_wr_en, 1);
        check("drain_addr", Rd_addr, 7);
        check("drain_data", Rd_wr_data, 32'h1234);
        check("drain_busy_wr", Rs1_busy, 0);
        check("drain_wb_ready", Wb_ready, 1);
        tick();
        #2;
        check("drain_empty", Ll_ready, 1);
        check("drain_busy_post", Rs1_busy, 0);
        check("drain_post_wr", Rd_wr_en, 0);

        // WAW on rd 9 plus starvation under continuous WB
        tick();
        Issue_valid = 1'b1; Issue_rd = 5'd9; Rs1_addr = 5'd9;
        #2;
        check("waw_first_issue", Issue_ready, 1);
        tick();
        Wb_valid = 1'b1; Wb_rd = 5'd10; Wb_data = 32'hA;
        Ll_valid = 1'b1; Ll_rd = 5'd9; Ll_data = 32'h99;
        #2;
        check("waw_blocked0", Issue_ready, 32'(!SB));
        check("starve_wb_addr0", Rd_addr, 10);
        check("starve_wb_ready0", Wb_ready, 1);
        tick();
        Ll_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("starve_wb_ready_c%0d", i), Wb_ready, 1);
            check($sformatf("starve_addr_c%0d", i), Rd_addr, 10);
            check($sformatf("starve_ll_full_c%0d", i), Ll_ready, 0);
            check($sformatf("waw_blocked_c%0d", i), Issue_ready, 32'(!SB));
            check($sformatf("waw_busy_c%0d", i), Rs1_busy, 32'(SB));
            tick();
        end
        #2;
        check("force_wb_ready", Wb_ready, 0);
        check("force_addr", Rd_addr, 9);
        check("force_data", Rd_wr_data, 32'h99);
        check("force_wr_en", Rd_wr_en, 1);
        check("waw_issue_open", Issue_ready, 1);
        check("force_busy_bypass", Rs1_busy, 0);
        tick();
        Issue_valid = 1'b0;
        #2;
        check("resume_wb_ready", Wb_ready, 1);
        check("resume_addr", Rd_addr, 10);
        check("resume_ll_ready", Ll_ready, 1);
        check("waw_bit_kept", Rs1_busy, 32'(SB));
        check("waw_issue_again", Issue_ready, 32'(!SB));
        check("rs2_x0_busy", Rs2_busy, 0);

        // Reset while a result is buffered
        tick();
        Wb_valid = 1'b0;
        Ll_valid = 1'b1; Ll_rd = 5'd12; Ll_data = 32'h55;
        tick();
        Ll_valid = 1'b0;
        Reset_n = 1'b0;
        #2;
        check("midrst_no_wr", Rd_wr_en, 0);
        tick();
        Reset_n = 1'b1;
        #2;
        check("midrst_ll_ready", Ll_ready, 1);
        check("midrst_no_stale", Rd_wr_en, 0);
        check("midrst_busy_clr", Rs1_busy, 0);
        check("midrst_issue", Issue_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
